// File: rtl/pll_cfg_responder_if.sv
// Management-port bundle between the NTSC/PAL switch sequencer (master)
// and the PLL configuration responder (slave).
interface pll_cfg_responder_if;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
    input  mgmt_readdata, mgmt_waitrequest
  );

  modport slave (
    input  mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
    output mgmt_readdata, mgmt_waitrequest
  );
endinterface

// File: rtl/pll_cfg_responder.sv
// PLL reconfiguration register file: shadow N/M/C/Mfrac registers are
// loaded over the management port and copied to the active outputs a
// fixed number of cycles after a START write, followed by a lock-settle
// interval during which cfg_locked is held low.
module pll_cfg_responder #(
  parameter int          NUM_C        = 2,
  parameter int          APPLY_CYCLES = 64,
  parameter int          LOCK_CYCLES  = 256,
  parameter logic [31:0] DEF_N        = 32'h00010000,
  parameter logic [31:0] DEF_M        = 32'h00000404,
  parameter logic [31:0] DEF_C        = 32'h00000505,
  parameter logic [31:0] DEF_FRAC     = 32'h9745BF27
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pll_cfg_responder_if.slave    mgmt,
  output logic [31:0]           cfg_n,
  output logic [31:0]           cfg_m,
  output logic [NUM_C*32-1:0]   cfg_c,
  output logic [31:0]           cfg_frac,
  output logic                  apply_stb,
  output logic                  cfg_locked
);

  localparam int APPLY_W = (APPLY_CYCLES < 2) ? 1 : $clog2(APPLY_CYCLES + 1);
  localparam int LOCK_W  = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [APPLY_W-1:0] APPLY_LOAD = APPLY_W'(APPLY_CYCLES);
  localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_COMMIT
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [APPLY_W-1:0]      apply_cnt;
  logic [LOCK_W-1:0]       lock_cnt;
  logic                    mode;
  logic                    err;
  logic [31:0]             shadow_n;
  logic [31:0]             shadow_m;
  logic [NUM_C-1:0][31:0]  shadow_c;
  logic [31:0]             shadow_frac;
  logic [NUM_C-1:0][31:0]  active_c;
  logic [31:0]             readdata;
  logic [31:0]             rd_val;
  logic                    busy;
  logic                    accept;
  logic                    do_write;
  logic                    do_read;
  logic                    start_go;
  logic                    commit_now;
  logic [4:0]              c_idx;
  logic                    c_ok;

  assign busy       = (state != ST_IDLE);
  assign accept     = (mgmt.mgmt_write | mgmt.mgmt_read) & ~mgmt.mgmt_waitrequest;
  assign do_write   = accept & mgmt.mgmt_write;
  assign do_read    = accept & ~mgmt.mgmt_write;
  assign start_go   = do_write & (mgmt.mgmt_address == 6'd2) & ~busy;
  assign commit_now = (state == ST_BUSY) && (apply_cnt == APPLY_W'(1));
  assign c_idx      = mgmt.mgmt_writedata[22:18];
  assign c_ok       = int'(c_idx) < NUM_C;

  assign cfg_c               = active_c;
  assign mgmt.mgmt_readdata  = readdata;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode plus the strobe and waitrequest, which follow the state directly
  always_comb begin
    state_nxt             = state;
    apply_stb             = 1'b0;
    mgmt.mgmt_waitrequest = ~mode & busy;
    case (state)
      ST_IDLE:   if (start_go) state_nxt = ST_BUSY;
      ST_BUSY:   if (commit_now) state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        apply_stb = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Apply delay counter, loaded on START and run down while BUSY
  always_ff @(posedge clk) begin
    if (!reset_n)               apply_cnt <= '0;
    else if (start_go)          apply_cnt <= APPLY_LOAD;
    else if (state == ST_BUSY)  apply_cnt <= apply_cnt - APPLY_W'(1);
  end

  // Lock settle counter, reloaded by reset and by every commit
  always_ff @(posedge clk) begin
    if (!reset_n || commit_now) begin
      lock_cnt   <= LOCK_LOAD;
      cfg_locked <= (LOCK_CYCLES == 0);
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - LOCK_W'(1);
      if (lock_cnt == LOCK_W'(1)) cfg_locked <= 1'b1;
    end
  end

  // Register file writes; shadow writes and START while busy are rejected into err
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode        <= 1'b0;
      err         <= 1'b0;
      shadow_n    <= DEF_N;
      shadow_m    <= DEF_M;
      shadow_c    <= {NUM_C{DEF_C}};
      shadow_frac <= DEF_FRAC;
      cfg_n       <= DEF_N;
      cfg_m       <= DEF_M;
      active_c    <= {NUM_C{DEF_C}};
      cfg_frac    <= DEF_FRAC;
    end else begin
      if (commit_now) begin
        cfg_n    <= shadow_n;
        cfg_m    <= shadow_m;
        active_c <= shadow_c;
        cfg_frac <= shadow_frac;
      end
      if (do_write) begin
        case (mgmt.mgmt_address)
          6'd0: mode <= mgmt.mgmt_writedata[0];
          6'd1: err  <= 1'b0;
          6'd2: if (busy) err <= 1'b1;
          6'd3: if (busy) err <= 1'b1; else shadow_n <= mgmt.mgmt_writedata;
          6'd4: if (busy) err <= 1'b1; else shadow_m <= mgmt.mgmt_writedata;
          6'd5: begin
            if (busy || !c_ok) begin
              err <= 1'b1;
            end else begin
              for (int i = 0; i < NUM_C; i++) begin
                if (int'(c_idx) == i) shadow_c[i] <= mgmt.mgmt_writedata;
              end
            end
          end
          6'd7: if (busy) err <= 1'b1; else shadow_frac <= mgmt.mgmt_writedata;
          default: ;
        endcase
      end
    end
  end

  // Read mux over the register map; C reads always return counter 0
  always_comb begin
    rd_val = '0;
    case (mgmt.mgmt_address)
      6'd0:    rd_val = {31'd0, mode};
      6'd1:    rd_val = {30'd0, err, ~busy};
      6'd3:    rd_val = shadow_n;
      6'd4:    rd_val = shadow_m;
      6'd5:    rd_val = shadow_c[0];
      6'd7:    rd_val = shadow_frac;
      default: rd_val = '0;
    endcase
  end

  // Registered read data, updated only by an accepted read
  always_ff @(posedge clk) begin
    if (!reset_n)     readdata <= '0;
    else if (do_read) readdata <= rd_val;
  end

endmodule

// File: tb/tb_pll_cfg_responder.sv
// Self-checking bench for pll_cfg_responder: directed scenarios followed by
// randomized management traffic, all compared against a timeline model
// that tracks commit and lock release as absolute clock-edge numbers.
module tb_pll_cfg_responder;

  localparam int          NUM_C    = 2;
  localparam int          APPLY    = 64;
  localparam int          LOCK     = 256;
  localparam logic [31:0] DEF_N    = 32'h00010000;
  localparam logic [31:0] DEF_M    = 32'h00000404;
  localparam logic [31:0] DEF_C    = 32'h00000505;
  localparam logic [31:0] DEF_FRAC = 32'h9745BF27;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pll_cfg_responder_if bus();

  logic [31:0]         cfg_n;
  logic [31:0]         cfg_m;
  logic [NUM_C*32-1:0] cfg_c;
  logic [31:0]         cfg_frac;
  logic                apply_stb;
  logic                cfg_locked;

  pll_cfg_responder #(
    .NUM_C(NUM_C), .APPLY_CYCLES(APPLY), .LOCK_CYCLES(LOCK),
    .DEF_N(DEF_N), .DEF_M(DEF_M), .DEF_C(DEF_C), .DEF_FRAC(DEF_FRAC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mgmt(bus),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c(cfg_c), .cfg_frac(cfg_frac),
    .apply_stb(apply_stb), .cfg_locked(cfg_locked)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Timeline model: everything keyed on the number of clock edges seen
  int          edge_n = 0;
  bit          pend = 0;
  int          commit_edge = 0;
  int          lock_edge = 0;
  bit          m_mode = 0;
  bit          m_err = 0;
  bit          m_acc = 0;
  logic [31:0] m_rd = '0;
  logic [31:0] sh_n, sh_m, sh_frac, act_n, act_m, act_frac;
  logic [31:0] sh_c [NUM_C];
  logic [31:0] act_c [NUM_C];

  // Single comparison point; every check is counted here
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_C*32-1:0] pack_c();
    logic [NUM_C*32-1:0] v;
    for (int i = 0; i < NUM_C; i++) v[i*32 +: 32] = act_c[i];
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge
  task automatic model_edge();
    int          k;
    int          idx;
    bit          busy;
    logic [31:0] rv;
    k = edge_n + 1;
    m_acc = 0;
    if (!reset_n) begin
      m_mode = 0; m_err = 0; pend = 0; m_rd = '0;
      lock_edge = k + LOCK;
      sh_n = DEF_N; sh_m = DEF_M; sh_frac = DEF_FRAC;
      act_n = DEF_N; act_m = DEF_M; act_frac = DEF_FRAC;
      for (int i = 0; i < NUM_C; i++) begin
        sh_c[i] = DEF_C;
        act_c[i] = DEF_C;
      end
    end else begin
      busy = pend;
      m_acc = (bus.mgmt_write || bus.mgmt_read) && !(!m_mode && busy);
      case (bus.mgmt_address)
        6'd0:    rv = {31'd0, m_mode};
        6'd1:    rv = {30'd0, m_err, !busy};
        6'd3:    rv = sh_n;
        6'd4:    rv = sh_m;
        6'd5:    rv = sh_c[0];
        6'd7:    rv = sh_frac;
        default: rv = '0;
      endcase
      if (pend && k == commit_edge) begin
        act_n = sh_n; act_m = sh_m; act_frac = sh_frac;
        for (int i = 0; i < NUM_C; i++) act_c[i] = sh_c[i];
        lock_edge = k + LOCK;
      end
      if (m_acc && bus.mgmt_write) begin
        case (bus.mgmt_address)
          6'd0: m_mode = bus.mgmt_writedata[0];
          6'd1: m_err = 0;
          6'd2: if (busy) m_err = 1; else begin pend = 1; commit_edge = k + APPLY; end
          6'd3: if (busy) m_err = 1; else sh_n = bus.mgmt_writedata;
          6'd4: if (busy) m_err = 1; else sh_m = bus.mgmt_writedata;
          6'd5: begin
            idx = int'(bus.mgmt_writedata[22:18]);
            if (busy || idx >= NUM_C) m_err = 1;
            else sh_c[idx] = bus.mgmt_writedata;
          end
          6'd7: if (busy) m_err = 1; else sh_frac = bus.mgmt_writedata;
          default: ;
        endcase
      end else if (m_acc) begin
        m_rd = rv;
      end
      if (pend && k > commit_edge) pend = 0;
    end
    edge_n = k;
  endtask

  // One clock: update the model at the edge, then compare all outputs 1 ns later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    checkOutput("readdata", bus.mgmt_readdata, m_rd);
    checkOutput("waitreq", bus.mgmt_waitrequest, !m_mode && pend);
    checkOutput("apply_stb", apply_stb, pend && edge_n == commit_edge);
    checkOutput("locked", cfg_locked, edge_n >= lock_edge);
    checkOutput("cfg_n", cfg_n, act_n);
    checkOutput("cfg_m", cfg_m, act_m);
    checkOutput("cfg_c", cfg_c, pack_c());
    checkOutput("cfg_frac", cfg_frac, act_frac);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Present a request and hold it until accepted, bounded by a cycle budget
  task automatic applyStimulus(input bit w, input bit r, input logic [5:0] a, input logic [31:0] wd);
    bit done;
    done = 0;
    bus.mgmt_write = w;
    bus.mgmt_read = r;
    bus.mgmt_address = a;
    bus.mgmt_writedata = wd;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = m_acc;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
    bus.mgmt_write = 0;
    bus.mgmt_read = 0;
  endtask

  task automatic readCheck(input logic [5:0] a, input logic [31:0] exp, input string tag);
    applyStimulus(0, 1, a, '0);
    checkOutput(tag, bus.mgmt_readdata, exp);
  endtask

  task automatic pulseReset();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  // Directed scenarios, then randomized traffic
  initial begin
    int acc_edge;
    int seen;
    int stb_count;
    int op;
    logic [5:0]  a;
    logic [31:0] d;

    bus.mgmt_write = 0;
    bus.mgmt_read = 0;
    bus.mgmt_address = '0;
    bus.mgmt_writedata = '0;

    reset_n = 0;
    idle(2);
    reset_n = 1;
    checkOutput("rst_n", cfg_n, DEF_N);
    checkOutput("rst_frac", cfg_frac, DEF_FRAC);
    checkOutput("rst_locked", cfg_locked, 0);
    idle(LOCK + 4);
    checkOutput("lock_after_rst", cfg_locked, 1);

    applyStimulus(1, 0, 6'd0, 32'h0);
    applyStimulus(1, 0, 6'd3, 32'h00010000);
    applyStimulus(1, 0, 6'd4, 32'h00000404);
    applyStimulus(1, 0, 6'd5, 32'h00020504);
    applyStimulus(1, 0, 6'd7, 32'hA3D709E8);
    applyStimulus(1, 0, 6'd2, 32'h0);
    acc_edge = edge_n;
    seen = -1;
    for (int i = 0; i < 100 && seen < 0; i++) begin
      tick();
      if (apply_stb === 1'b1) seen = edge_n;
    end
    checkOutput("stb_delay", seen - acc_edge, APPLY);
    checkOutput("c0_commit", cfg_c[31:0], 32'h00020504);
    checkOutput("frac_commit", cfg_frac, 32'hA3D709E8);
    checkOutput("lock_drop", cfg_locked, 0);

    applyStimulus(1, 0, 6'd2, 32'h0);
    acc_edge = edge_n;
    idle(10);
    checkOutput("wr_busy", bus.mgmt_waitrequest, 1);
    applyStimulus(1, 0, 6'd3, 32'h00020000);
    checkOutput("held_after_commit", edge_n > acc_edge + APPLY, 1);
    checkOutput("n_unchanged", cfg_n, 32'h00010000);
    applyStimulus(1, 0, 6'd2, 32'h0);
    idle(APPLY + 2);
    checkOutput("n_next_start", cfg_n, 32'h00020000);

    applyStimulus(1, 0, 6'd0, 32'h1);
    applyStimulus(1, 0, 6'd2, 32'h0);
    idle(5);
    applyStimulus(1, 0, 6'd4, 32'h1);
    readCheck(6'd1, 32'h2, "status_busy");
    idle(APPLY + 2);
    readCheck(6'd1, 32'h3, "status_done");
    checkOutput("m_dropped", cfg_m, 32'h00000404);

    applyStimulus(1, 0, 6'd1, 32'h0);
    readCheck(6'd1, 32'h1, "status_clr");
    applyStimulus(1, 0, 6'd5, 32'h000C1111);
    readCheck(6'd1, 32'h3, "status_cidx");
    readCheck(6'd5, 32'h00020504, "c0_kept");
    applyStimulus(1, 0, 6'd1, 32'h0);
    readCheck(6'd1, 32'h1, "status_clr2");
    readCheck(6'd6, 32'h0, "unmapped");

    applyStimulus(1, 0, 6'd0, 32'h0);
    applyStimulus(1, 0, 6'd3, 32'h00030000);
    applyStimulus(1, 0, 6'd2, 32'h0);
    idle(29);
    pulseReset();
    stb_count = 0;
    for (int i = 0; i < LOCK + 10; i++) begin
      tick();
      if (apply_stb === 1'b1) stb_count++;
    end
    checkOutput("abort_no_stb", stb_count, 0);
    checkOutput("abort_n_def", cfg_n, DEF_N);

    for (int t = 0; t < 300; t++) begin
      idle($urandom_range(0, 3));
      op = $urandom_range(0, 99);
      d = $urandom();
      if (op < 3) begin
        pulseReset();
      end else if (op < 10) begin
        applyStimulus(1, 0, 6'd2, d);
      end else if (op < 18) begin
        applyStimulus(1, 0, 6'd0, d);
      end else if (op < 22) begin
        applyStimulus(1, 0, 6'd1, d);
      end else if (op < 60) begin
        case ($urandom_range(0, 4))
          0: a = 6'd3;
          1: a = 6'd4;
          2: a = 6'd5;
          3: a = 6'd7;
          default: a = 6'($urandom_range(0, 63));
        endcase
        if (a == 6'd5) d[22:18] = 5'($urandom_range(0, 3));
        if (a == 6'd2) a = 6'd6;
        applyStimulus(1, 0, a, d);
      end else begin
        a = 6'($urandom_range(0, 8));
        applyStimulus(($urandom_range(0, 9) == 0), 1, a, d);
      end
    end
    idle(APPLY + LOCK + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
